compression_dispatch_scheduler: RTL and testbench

- Sequences the shared compression engine across the NUM_STREAM_ELEMENTS stream elements in strict token (record) order.
- Selects which element's uncompressed record is muxed into the compression engine. Issues a one-cycle data-taken pulse to that element only when the engine can ingest.
- Inserts settle cycles so the engine's byte count can update before the next issue.
- Provides dispatch statistics and a sticky ordering-stall watchdog.

---
 rtl/compression_dispatch_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_compression_dispatch_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/compression_dispatch_scheduler.sv
// -----------------------------------------------------------------------------
// compression_dispatch_scheduler
//
// Purpose:
//   Time-shares a single compression engine across NUM_STREAM_ELEMENTS stream
//   elements in strict round-robin token order. The element pointed at by
//   use_sel is muxed into the engine. When that element holds a record and
//   the engine has room, a one-cycle data-taken pulse is sent to the element
//   and the pointer advances. After every take the scheduler idles for
//   SETTLE_CYCLES so the engine's byte count can reflect the new record
//   before the next decision. It also keeps dispatch statistics and a sticky
//   watchdog that flags prolonged ordering stalls.
//
// Ports:
//   clk              in   clock
//   resetn           in   asynchronous, active-low reset
//   enable           in   dispatch permitted when 1
//   use_byte_counts  in   N x 8 pending byte counts, element i at [i*8 +: 8]
//   cse_byte_count   in   bytes pending inside the compression engine
//   cse_shift        in   engine is draining into its return FIFO this cycle
//   use_sel          out  index of the element muxed into the engine
//   use_taken        out  one-hot data-taken pulse (combinational)
//   dispatch_count   out  records dispatched, wraps at 2^32
//   stall_cycles     out  length of the current stall, saturates at 0xFFFF
//   order_stall_err  out  sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module compression_dispatch_scheduler #(
  parameter int NUM_STREAM_ELEMENTS    = 4,
  parameter int MAX_UNCOMPRESSED_BYTES = 34,
  parameter int FIFO_MAX_INGEST_BYTES  = 16,
  parameter int SETTLE_CYCLES          = 1,
  parameter int WATCHDOG_CYCLES        = 1024
) (
  input  logic                                        clk,
  input  logic                                        resetn,
  input  logic                                        enable,
  input  logic [NUM_STREAM_ELEMENTS*8-1:0]            use_byte_counts,
  input  logic [$clog2(MAX_UNCOMPRESSED_BYTES*8)-1:0] cse_byte_count,
  input  logic                                        cse_shift,
  output logic [$clog2(NUM_STREAM_ELEMENTS)-1:0]      use_sel,
  output logic [NUM_STREAM_ELEMENTS-1:0]              use_taken,
  output logic [31:0]                                 dispatch_count,
  output logic [15:0]                                 stall_cycles,
  output logic                                        order_stall_err
);

  localparam int SEL_W = $clog2(NUM_STREAM_ELEMENTS);
  localparam int CNT_W = $clog2(MAX_UNCOMPRESSED_BYTES*8);

  localparam logic [CNT_W-1:0] INGEST_LIMIT = CNT_W'(FIFO_MAX_INGEST_BYTES);
  localparam logic [3:0]       SETTLE_LOAD  = 4'(SETTLE_CYCLES - 1);
  localparam logic [15:0]      WDG_LIMIT    = 16'(WATCHDOG_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_ONE      = SEL_W'(1);

  typedef enum logic [0:0] {
    ST_READY  = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

  state_e             state_q,    state_d;
  logic [SEL_W-1:0]   sel_q,      sel_d;
  logic [3:0]         settle_q,   settle_d;
  logic [31:0]        dispatch_q, dispatch_d;
  logic [15:0]        stall_q,    stall_d;
  logic               err_q,      err_d;

  logic [7:0]         counts_s [NUM_STREAM_ELEMENTS];
  logic [7:0]         cur_s;
  logic               others_busy_s;
  logic               room_s;
  logic               issue_s;
  logic               stalled_s;

  // Unpack the flat count bus into one byte per element.
  for (genvar g = 0; g < NUM_STREAM_ELEMENTS; g++) begin : g_unpack
    assign counts_s[g] = use_byte_counts[g*8 +: 8];
  end

  // Current-element count and whether any other element is waiting.
  always_comb begin
    cur_s         = counts_s[sel_q];
    others_busy_s = 1'b0;
    for (int i = 0; i < NUM_STREAM_ELEMENTS; i++) begin
      if ((SEL_W'(i) != sel_q) && (counts_s[i] != 8'd0)) begin
        others_busy_s = 1'b1;
      end else begin
        others_busy_s = others_busy_s;
      end
    end
  end

  // Engine room, issue decision and stall classification.
  always_comb begin
    room_s = (cse_byte_count == {CNT_W{1'b0}}) ||
             ((cse_byte_count < INGEST_LIMIT) && cse_shift);
    // resetn gates issue so no pulse escapes while the flops sit in reset.
    issue_s = resetn && (state_q == ST_READY) && enable &&
              (cur_s != 8'd0) && room_s;
    // Strict ordering: an empty current element blocks everyone behind it.
    stalled_s = ((cur_s == 8'd0) && others_busy_s) ||
                ((cur_s != 8'd0) && !room_s);
  end

  // One-hot take pulse toward the selected element.
  always_comb begin
    use_taken = {NUM_STREAM_ELEMENTS{1'b0}};
    if (issue_s) begin
      use_taken[sel_q] = 1'b1;
    end else begin
      use_taken = {NUM_STREAM_ELEMENTS{1'b0}};
    end
  end

  // Next-state logic for the dispatch FSM, statistics and watchdog.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    settle_d   = settle_q;
    dispatch_d = dispatch_q;
    stall_d    = stall_q;
    err_d      = err_q;
    case (state_q)
      ST_READY: begin
        if (issue_s) begin
          state_d    = ST_SETTLE;
          settle_d   = SETTLE_LOAD;
          sel_d      = sel_q + SEL_ONE;  // power-of-two count wraps naturally
          dispatch_d = dispatch_q + 32'd1;
          stall_d    = 16'd0;
        end else if (enable) begin
          if (stalled_s) begin
            if (stall_q >= WDG_LIMIT) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            if (stall_q != 16'hFFFF) begin
              stall_d = stall_q + 16'd1;
            end else begin
              stall_d = stall_q;
            end
          end else begin
            stall_d = 16'd0;
          end
        end else begin
          // Disabled: everything holds.
          stall_d = stall_q;
        end
      end
      ST_SETTLE: begin
        // Settling runs to completion independent of enable.
        if (settle_q == 4'd0) begin
          state_d = ST_READY;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      default: begin
        state_d  = ST_READY;
        settle_d = 4'd0;
      end
    endcase
  end

  // State and statistics registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_READY;
      sel_q      <= {SEL_W{1'b0}};
      settle_q   <= 4'd0;
      dispatch_q <= 32'd0;
      stall_q    <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      settle_q   <= settle_d;
      dispatch_q <= dispatch_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
    end
  end

  assign use_sel         = sel_q;
  assign dispatch_count  = dispatch_q;
  assign stall_cycles    = stall_q;
  assign order_stall_err = err_q;

endmodule

// File: tb/tb_compression_dispatch_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for compression_dispatch_scheduler.
// A table of hand-derived vectors covers the directed scenarios, a short
// hand-written sequence covers asynchronous reset mid-operation, and a
// randomized phase is compared against a cycle-count based reference model.
// -----------------------------------------------------------------------------
module tb_compression_dispatch_scheduler;

  localparam int N      = 4;
  localparam int SETTLE = 1;
  localparam int WDG    = 8;
  localparam int FIFO   = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [31:0] counts;
  logic [8:0]  cse;
  logic        cse_shift;
  logic [1:0]  use_sel;
  logic [3:0]  use_taken;
  logic [31:0] dispatch_count;
  logic [15:0] stall_cycles;
  logic        order_stall_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  compression_dispatch_scheduler #(
    .NUM_STREAM_ELEMENTS   (N),
    .MAX_UNCOMPRESSED_BYTES(34),
    .FIFO_MAX_INGEST_BYTES (FIFO),
    .SETTLE_CYCLES         (SETTLE),
    .WATCHDOG_CYCLES       (WDG)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .use_byte_counts(counts),
    .cse_byte_count (cse),
    .cse_shift      (cse_shift),
    .use_sel        (use_sel),
    .use_taken      (use_taken),
    .dispatch_count (dispatch_count),
    .stall_cycles   (stall_cycles),
    .order_stall_err(order_stall_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the next cycle at which a take is allowed instead of an FSM.
  int          cyc;
  int          m_next_ok;
  int          m_sel;
  logic [31:0] m_disp;
  int          m_stall;
  bit          m_err;
  bit          e_issue, e_ready, e_room;

  function automatic int cnt_of(input int i);
    return int'(counts[i*8 +: 8]);
  endfunction

  task automatic model_reset();
    m_sel     = 0;
    m_disp    = 32'd0;
    m_stall   = 0;
    m_err     = 1'b0;
    m_next_ok = cyc;
  endtask

  task automatic model_eval(input bit do_chk);
    logic [3:0] exp_t;
    e_room  = (cse == 9'd0) || ((int'(cse) < FIFO) && cse_shift);
    e_ready = (cyc >= m_next_ok);
    e_issue = e_ready && enable && (cnt_of(m_sel) > 0) && e_room;
    exp_t   = e_issue ? (4'b0001 << m_sel) : 4'b0000;
    if (do_chk) begin
      chk($sformatf("rand%0d_taken", cyc), {28'd0, use_taken}, {28'd0, exp_t});
      chk($sformatf("rand%0d_sel", cyc), {30'd0, use_sel}, m_sel);
      chk($sformatf("rand%0d_disp", cyc), dispatch_count, m_disp);
      chk($sformatf("rand%0d_stall", cyc), {16'd0, stall_cycles}, m_stall);
      chk($sformatf("rand%0d_err", cyc), {31'd0, order_stall_err}, {31'd0, m_err});
    end
  endtask

  task automatic model_commit();
    bit others, stalled;
    if (e_issue) begin
      m_sel     = (m_sel + 1) % N;
      m_disp    = m_disp + 32'd1;
      m_stall   = 0;
      m_next_ok = cyc + SETTLE + 1;
    end else if (e_ready && enable) begin
      others = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (j != m_sel && cnt_of(j) > 0) others = 1'b1;
      end
      stalled = ((cnt_of(m_sel) == 0) && others) || ((cnt_of(m_sel) > 0) && !e_room);
      if (stalled) begin
        if (m_stall >= WDG - 1) m_err = 1'b1;
        if (m_stall < 65535) m_stall++;
      end else begin
        m_stall = 0;
      end
    end
    cyc++;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        pre_reset;
    logic        en;
    logic [31:0] cnts;
    logic [8:0]  cse;
    logic        shift;
    logic [3:0]  taken;
    logic [1:0]  sel;
    logic [31:0] disp;
    logic [15:0] stall;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pre, input logic en, input logic [31:0] c,
                     input logic [8:0] cb, input logic sh, input logic [3:0] tk,
                     input logic [1:0] sl, input logic [31:0] dc,
                     input logic [15:0] st, input logic er);
    vec_t v;
    v.pre_reset = pre; v.en = en; v.cnts = c; v.cse = cb; v.shift = sh;
    v.taken = tk; v.sel = sl; v.disp = dc; v.stall = st; v.err = er;
    vecs.push_back(v);
  endtask

  // Drop resetn between clock edges while in SETTLE and check the outputs
  // clear without a clock edge.
  task automatic mid_op_reset();
    chk("pre_rst_sel", {30'd0, use_sel}, 32'd3);
    chk("pre_rst_disp", dispatch_count, 32'd7);
    chk("pre_rst_err", {31'd0, order_stall_err}, 32'd1);
    enable = 1'b1; counts = 32'h0000_0005; cse = 9'd0; cse_shift = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("async_sel", {30'd0, use_sel}, 32'd0);
    chk("async_disp", dispatch_count, 32'd0);
    chk("async_stall", {16'd0, stall_cycles}, 32'd0);
    chk("async_err", {31'd0, order_stall_err}, 32'd0);
    chk("async_taken", {28'd0, use_taken}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_taken", {28'd0, use_taken}, 32'd0);
    resetn = 1'b1;
  endtask

  initial begin
    vec_t r;
    cyc       = 0;
    resetn    = 1'b0;
    enable    = 1'b1;
    counts    = 32'h0000_0005;
    cse       = 9'd0;
    cse_shift = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_taken", {28'd0, use_taken}, 32'd0);
    chk("reset_sel", {30'd0, use_sel}, 32'd0);
    chk("reset_disp", dispatch_count, 32'd0);
    chk("reset_stall", {16'd0, stall_cycles}, 32'd0);
    chk("reset_err", {31'd0, order_stall_err}, 32'd0);
    resetn = 1'b1;

    // single record on element 0, then element 1 empty
    add(0, 1, 32'h0000000C, 9'd0, 0, 4'b0001, 2'd0, 32'd0, 16'd0, 0);
    add(0, 1, 32'h0000000C, 9'd0, 0, 4'b0000, 2'd1, 32'd1, 16'd0, 0);
    add(0, 1, 32'h0000000C, 9'd0, 0, 4'b0000, 2'd1, 32'd1, 16'd0, 0);
    add(0, 1, 32'h00000000, 9'd0, 0, 4'b0000, 2'd1, 32'd1, 16'd1, 0);
    add(0, 1, 32'h00000000, 9'd0, 0, 4'b0000, 2'd1, 32'd1, 16'd0, 0);
    // all elements loaded: take every other cycle, pointer wraps 3 -> 0
    add(0, 1, 32'h14141414, 9'd0, 0, 4'b0010, 2'd1, 32'd1, 16'd0, 0);
    add(0, 1, 32'h14141414, 9'd0, 0, 4'b0000, 2'd2, 32'd2, 16'd0, 0);
    add(0, 1, 32'h14141414, 9'd0, 0, 4'b0100, 2'd2, 32'd2, 16'd0, 0);
    add(0, 1, 32'h14141414, 9'd0, 0, 4'b0000, 2'd3, 32'd3, 16'd0, 0);
    add(0, 1, 32'h14141414, 9'd0, 0, 4'b1000, 2'd3, 32'd3, 16'd0, 0);
    add(0, 1, 32'h14141414, 9'd0, 0, 4'b0000, 2'd0, 32'd4, 16'd0, 0);
    add(0, 1, 32'h14141414, 9'd0, 0, 4'b0001, 2'd0, 32'd4, 16'd0, 0);
    add(0, 1, 32'h14141414, 9'd0, 0, 4'b0000, 2'd1, 32'd5, 16'd0, 0);
    add(0, 1, 32'h14141414, 9'd0, 0, 4'b0010, 2'd1, 32'd5, 16'd0, 0);
    add(0, 1, 32'h14141414, 9'd0, 0, 4'b0000, 2'd2, 32'd6, 16'd0, 0);
    // ordering stall on empty element 2 while 3 waits; watchdog after 8
    for (int k = 1; k <= 9; k++) begin
      add(0, 1, 32'h09000000, 9'd0, 0, 4'b0000, 2'd2, 32'd6, 16'(k - 1), (k >= 9));
    end
    add(0, 1, 32'h09050000, 9'd0, 0, 4'b0100, 2'd2, 32'd6, 16'd9, 1);
    // after mid-operation reset: engine full, then disabled, then room
    add(1, 1, 32'h0000000A, 9'd20, 1, 4'b0000, 2'd0, 32'd0, 16'd0, 0);
    add(0, 1, 32'h0000000A, 9'd20, 1, 4'b0000, 2'd0, 32'd0, 16'd1, 0);
    add(0, 1, 32'h0000000A, 9'd20, 1, 4'b0000, 2'd0, 32'd0, 16'd2, 0);
    add(0, 0, 32'h00000005, 9'd0,  0, 4'b0000, 2'd0, 32'd0, 16'd3, 0);
    add(0, 0, 32'h00000005, 9'd0,  0, 4'b0000, 2'd0, 32'd0, 16'd3, 0);
    add(0, 1, 32'h0000000A, 9'd8,  1, 4'b0001, 2'd0, 32'd0, 16'd3, 0);
    add(0, 1, 32'h0000000A, 9'd8,  1, 4'b0000, 2'd1, 32'd1, 16'd0, 0);
    // room boundaries: 16 with shift blocks, 15 without shift blocks,
    // 0 with shift admits
    add(0, 1, 32'h00000700, 9'd16, 1, 4'b0000, 2'd1, 32'd1, 16'd0, 0);
    add(0, 1, 32'h00000700, 9'd15, 0, 4'b0000, 2'd1, 32'd1, 16'd1, 0);
    add(0, 1, 32'h00000700, 9'd0,  1, 4'b0010, 2'd1, 32'd1, 16'd2, 0);
    add(0, 1, 32'h00000700, 9'd0,  1, 4'b0000, 2'd2, 32'd2, 16'd0, 0);

    foreach (vecs[i]) begin
      r = vecs[i];
      if (r.pre_reset) mid_op_reset();
      enable = r.en; counts = r.cnts; cse = r.cse; cse_shift = r.shift;
      @(negedge clk);
      chk($sformatf("row%0d_taken", i), {28'd0, use_taken}, {28'd0, r.taken});
      chk($sformatf("row%0d_sel", i), {30'd0, use_sel}, {30'd0, r.sel});
      chk($sformatf("row%0d_disp", i), dispatch_count, r.disp);
      chk($sformatf("row%0d_stall", i), {16'd0, stall_cycles}, {16'd0, r.stall});
      chk($sformatf("row%0d_err", i), {31'd0, order_stall_err}, {31'd0, r.err});
      model_eval(1'b0);
      @(posedge clk);
      model_commit();
      #1;
    end

    // randomized phase against the reference model
    for (int n = 0; n < 3000; n++) begin
      if ((n % 600) == 599) begin
        resetn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
      end
      enable = ($urandom_range(0, 9) != 0);
      for (int e = 0; e < N; e++) begin
        counts[e*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 34));
      end
      case ($urandom_range(0, 3))
        0:       cse = 9'd0;
        1:       cse = 9'($urandom_range(1, 15));
        2:       cse = 9'd16;
        default: cse = 9'($urandom_range(17, 271));
      endcase
      cse_shift = $urandom_range(0, 1) != 0;
      @(negedge clk);
      model_eval(1'b1);
      @(posedge clk);
      model_commit();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
